// File: rtl/babbage_stream_if.sv
// Request/response bundle for babbage_stream.
// Request side: in_val/in_rdy handshake carrying start point x, point count n
// and packed coefficients coef (a_k at coef[k*CW +: CW]).
// Response side: out_val/out_rdy handshake carrying y and the out_last marker.
// slave: the evaluator; master: the source/consumer side.
interface babbage_stream_if #(
  parameter int unsigned DEG = 3,
  parameter int unsigned CW  = 8,
  parameter int unsigned XW  = 8,
  parameter int unsigned NW  = 16,
  parameter int unsigned YW  = 48
);
  logic                  in_val;
  logic                  in_rdy;
  logic [XW-1:0]         x;
  logic [NW-1:0]         n;
  logic [(DEG+1)*CW-1:0] coef;
  logic                  out_val;
  logic                  out_rdy;
  logic [YW-1:0]         y;
  logic                  out_last;

  modport slave (
    input  in_val, x, n, coef, out_rdy,
    output in_rdy, out_val, y, out_last
  );

  modport master (
    output in_val, x, n, coef, out_rdy,
    input  in_rdy, out_val, y, out_last
  );
endinterface

// File: rtl/babbage_stream.sv
// Streams p(x), p(x+1), ..., p(x+n-1) for a degree-DEG polynomial.
// The forward-difference table is seeded by Horner evaluation of p(x+j),
// j=0..DEG (one multiply-accumulate per cycle), converted to differences in
// DEG passes, then each output costs one cycle of additions.
// Ports: clk, rst (async active-low), bus (babbage_stream_if.slave).
// All arithmetic wraps modulo 2^YW.
module babbage_stream #(
  parameter int unsigned DEG = 3,
  parameter int unsigned CW  = 8,
  parameter int unsigned XW  = 8,
  parameter int unsigned NW  = 16,
  parameter int unsigned YW  = 48
) (
  input  logic               clk,
  input  logic               rst,
  babbage_stream_if.slave    bus
);
  localparam int unsigned CTW = $clog2(DEG + 2);

  typedef enum logic [1:0] {IDLE, SEED, DIFF, RUN} state_t;

  state_t          state_q, state_d;
  logic [YW-1:0]   t_q [DEG+1];
  logic [YW-1:0]   t_d [DEG+1];
  logic [CW-1:0]   a_q [DEG+1];
  logic [CW-1:0]   a_d [DEG+1];
  logic [XW-1:0]   x_q, x_d;
  logic [NW-1:0]   cnt_q, cnt_d;
  logic [CTW-1:0]  step_q, step_d;
  logic [CTW-1:0]  pt_q, pt_d;
  logic [YW-1:0]   acc_q, acc_d;
  logic            in_rdy_q, in_rdy_d;
  logic            out_val_q, out_val_d;
  logic            out_last_q, out_last_d;
  logic [YW-1:0]   y_q, y_d;

  logic [YW-1:0]   xj;
  logic [YW-1:0]   src;
  logic [CW-1:0]   a_sel;
  logic [YW-1:0]   mac;

  assign bus.in_rdy   = in_rdy_q;
  assign bus.out_val  = out_val_q;
  assign bus.out_last = out_last_q;
  assign bus.y        = y_q;

  // Horner step for point x+pt: step 0 starts from a_DEG, later steps from acc.
  always_comb begin
    xj    = YW'(x_q) + YW'(pt_q);
    src   = (step_q == '0) ? YW'(a_q[DEG]) : acc_q;
    a_sel = '0;
    for (int k = 0; k < int'(DEG); k++) begin
      if (k + int'(step_q) == int'(DEG) - 1) a_sel = a_q[k];
    end
    mac = src * xj + YW'(a_sel);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    a_d     = a_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    pt_d    = pt_q;
    acc_d   = acc_q;

    case (state_q)
      IDLE: begin
        if (bus.in_val && in_rdy_q) begin
          x_d    = bus.x;
          cnt_d  = (bus.n == '0) ? NW'(1) : bus.n;
          for (int k = 0; k <= int'(DEG); k++) a_d[k] = bus.coef[k*CW +: CW];
          step_d = '0;
          pt_d   = '0;
          state_d = SEED;
        end
      end
      SEED: begin
        acc_d = mac;
        if (step_q == CTW'(DEG - 1)) begin
          for (int j = 0; j <= int'(DEG); j++) begin
            if (j == int'(pt_q)) t_d[j] = mac;
          end
          step_d = '0;
          if (pt_q == CTW'(DEG)) begin
            pt_d    = '0;
            state_d = DIFF;
          end else begin
            pt_d = pt_q + CTW'(1);
          end
        end else begin
          step_d = step_q + CTW'(1);
        end
      end
      DIFF: begin
        // Pass step_q+1 differences every entry above it, all from pre-edge values.
        for (int j = 1; j <= int'(DEG); j++) begin
          if (j > int'(step_q)) t_d[j] = t_q[j] - t_q[j-1];
        end
        if (step_q == CTW'(DEG - 1)) begin
          step_d  = '0;
          state_d = RUN;
        end else begin
          step_d = step_q + CTW'(1);
        end
      end
      RUN: begin
        if (bus.out_rdy) begin
          for (int j = 0; j < int'(DEG); j++) t_d[j] = t_q[j] + t_q[j+1];
          cnt_d = cnt_q - NW'(1);
          if (cnt_q == NW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_rdy_d   = (state_d == IDLE);
    out_val_d  = (state_d == RUN);
    out_last_d = (state_d == RUN) && (cnt_d == NW'(1));
    y_d        = (state_d == RUN) ? t_d[0] : y_q;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      for (int j = 0; j <= int'(DEG); j++) begin
        t_q[j] <= '0;
        a_q[j] <= '0;
      end
      x_q        <= '0;
      cnt_q      <= '0;
      step_q     <= '0;
      pt_q       <= '0;
      acc_q      <= '0;
      in_rdy_q   <= 1'b1;
      out_val_q  <= 1'b0;
      out_last_q <= 1'b0;
      y_q        <= '0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      a_q        <= a_d;
      x_q        <= x_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      pt_q       <= pt_d;
      acc_q      <= acc_d;
      in_rdy_q   <= in_rdy_d;
      out_val_q  <= out_val_d;
      out_last_q <= out_last_d;
      y_q        <= y_d;
    end
  end
endmodule

// File: tb/tb_babbage_stream.sv
// Directed bench for babbage_stream: a YW=48 instance and a YW=16 instance
// share one set of request/consumer drivers; sel picks the active one.
module tb_babbage_stream;
  localparam int unsigned DEG = 3;
  localparam int unsigned CW  = 8;
  localparam int unsigned XW  = 8;
  localparam int unsigned NW  = 16;
  localparam logic [31:0] COEF_A = 32'h01020304;  // a3..a0 = 1,2,3,4

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  babbage_stream_if #(.DEG(DEG), .CW(CW), .XW(XW), .NW(NW), .YW(48)) bi ();
  babbage_stream_if #(.DEG(DEG), .CW(CW), .XW(XW), .NW(NW), .YW(16)) bj ();

  babbage_stream #(.DEG(DEG), .CW(CW), .XW(XW), .NW(NW), .YW(48)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bi.slave)
  );

  babbage_stream #(.DEG(DEG), .CW(CW), .XW(XW), .NW(NW), .YW(16)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bj.slave)
  );

  logic                  sel;
  logic                  in_val;
  logic [XW-1:0]         x;
  logic [NW-1:0]         n;
  logic [(DEG+1)*CW-1:0] coef;
  logic                  out_rdy;

  assign bi.in_val  = in_val & ~sel;
  assign bj.in_val  = in_val & sel;
  assign bi.x       = x;
  assign bj.x       = x;
  assign bi.n       = n;
  assign bj.n       = n;
  assign bi.coef    = coef;
  assign bj.coef    = coef;
  assign bi.out_rdy = out_rdy;
  assign bj.out_rdy = out_rdy;

  logic        ov, ol, ir;
  logic [47:0] yv;
  assign ov = sel ? bj.out_val  : bi.out_val;
  assign ol = sel ? bj.out_last : bi.out_last;
  assign ir = sel ? bj.in_rdy   : bi.in_rdy;
  assign yv = sel ? {32'd0, bj.y} : bi.y;

  int n_tests = 0;
  int n_fail  = 0;
  logic [47:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present a request and hold it until accepted (bounded).
  task automatic accept(input logic [XW-1:0] xv, input logic [NW-1:0] nv, input logic [31:0] cv);
    int b;
    @(negedge clk);
    x = xv; n = nv; coef = cv; in_val = 1'b1;
    b = 0;
    while (!ir && b < 50) begin
      @(negedge clk);
      b++;
    end
    check("accept_rdy", 64'(ir), 64'd1);
    @(posedge clk);
    #1 in_val = 1'b0;
  endtask

  // Cycles from accept edge until out_val is first seen.
  task automatic wait_out(input string tag, input int lat);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!ov && t < 100);
    check(tag, 64'(t - 1), 64'(lat));
  endtask

  // Drain exp_q; alt toggles out_rdy 1,0,1,0,... and checks holds while stalled.
  task automatic collect(input string tag, input bit alt);
    int i, cyc, nexp;
    bit held;
    logic [47:0] hy;
    i = 0; cyc = 0; held = 1'b0; hy = '0;
    nexp = exp_q.size();
    while (i < nexp && cyc < 200) begin
      if (held) begin
        check({tag, "_hold_y"}, 64'(yv), 64'(hy));
        check({tag, "_hold_val"}, 64'(ov), 64'd1);
        held = 1'b0;
      end
      out_rdy = alt ? (cyc % 2 == 0) : 1'b1;
      if (ov) begin
        if (out_rdy) begin
          check({tag, "_y"}, 64'(yv), 64'(exp_q[i]));
          check({tag, "_last"}, 64'(ol), 64'(i == nexp - 1));
          i++;
        end else begin
          held = 1'b1;
          hy   = yv;
        end
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, "_count"}, 64'(i), 64'(nexp));
    check({tag, "_idle_val"}, 64'(ov), 64'd0);
    check({tag, "_idle_rdy"}, 64'(ir), 64'd1);
    out_rdy = 1'b1;
  endtask

  task automatic expect_silence(input string tag, input int cycles);
    int hi;
    hi = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (ov) hi++;
    end
    check(tag, 64'(hi), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    sel = 1'b0; in_val = 1'b0; x = '0; n = '0; coef = '0; out_rdy = 1'b1;
    #2 rst = 1'b0;
    #3;
    check("rst_in_rdy",   64'(bi.in_rdy),   64'd1);
    check("rst_out_val",  64'(bi.out_val),  64'd0);
    check("rst_out_last", 64'(bi.out_last), 64'd0);
    check("rst_y",        64'(bi.y),        64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // p(2) = 26, single point
    accept(8'd2, 16'd1, COEF_A);
    wait_out("t1_lat", 15);
    exp_q = {48'd26};
    collect("t1", 1'b0);

    // x=0, n=5, continuous consumer
    accept(8'd0, 16'd5, COEF_A);
    wait_out("t2_lat", 15);
    exp_q = {48'd4, 48'd10, 48'd26, 48'd58, 48'd112};
    collect("t2", 1'b0);

    // Same request with alternating backpressure
    accept(8'd0, 16'd5, COEF_A);
    wait_out("t3_lat", 15);
    exp_q = {48'd4, 48'd10, 48'd26, 48'd58, 48'd112};
    collect("t3", 1'b1);

    // YW=16 wrap: 40^3 = 64000, 41^3 mod 65536 = 3385
    sel = 1'b1;
    accept(8'd40, 16'd2, 32'h01000000);
    wait_out("t4_lat", 15);
    exp_q = {48'd64000, 48'd3385};
    collect("t4", 1'b0);
    sel = 1'b0;

    // Reset during the third output cycle
    accept(8'd0, 16'd5, COEF_A);
    wait_out("t5_lat", 15);
    check("t5_y0", 64'(yv), 64'd4);
    @(negedge clk);
    check("t5_y1", 64'(yv), 64'd10);
    @(negedge clk);
    check("t5_y2", 64'(yv), 64'd26);
    rst = 1'b0;
    #1;
    check("t5_rst_val",  64'(ov), 64'd0);
    check("t5_rst_y",    64'(yv), 64'd0);
    check("t5_rst_last", 64'(ol), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rel_rdy", 64'(ir), 64'd1);
    expect_silence("t5_no_out", 25);
    accept(8'd1, 16'd1, COEF_A);
    wait_out("t5b_lat", 15);
    exp_q = {48'd10};
    collect("t5b", 1'b0);

    // n=0 behaves as n=1; in_val held high during SEED/RUN is ignored
    accept(8'd3, 16'd0, COEF_A);
    x = 8'd5; n = 16'd3; in_val = 1'b1;
    wait_out("t6_lat", 15);
    exp_q = {48'd58};
    collect("t6", 1'b0);
    in_val = 1'b0;
    expect_silence("t6_no_extra", 25);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
